// File: rtl/crtc_preset_loader.sv
// Loads one of four built-in R0-R15 register sets into the UM6845R over its host port,
// yielding to CPU traffic and restoring the CPU's register index afterwards.
// Optional build macro: CRTC_PRESET_LOCK_EN (block CPU writes while a load is busy).
module crtc_preset_loader (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       preset_req,
  input  logic [1:0] preset_sel,
  output logic       preset_busy,
  output logic       preset_done,
  input  logic       cpu_en,
  input  logic       cpu_ncs,
  input  logic       cpu_rnw,
  input  logic       cpu_rs,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       crtc_enable,
  output logic       crtc_ncs,
  output logic       crtc_rnw,
  output logic       crtc_rs,
  output logic [7:0] crtc_di,
  input  logic [7:0] crtc_do
);

  typedef enum logic [2:0] {IDLE, SEL, DAT, RESTORE, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [1:0] psel, psel_nxt;
  logic [4:0] sh;

  logic       cpu_strobe;
  logic       cpu_sel_wr;
  logic       cpu_fwd;
  logic       busy_int;
  logic       ld_drive;
  logic       ld_rs;
  logic [7:0] ld_di;
  logic       done_int;

  assign cpu_strobe = cpu_en & ~cpu_ncs;
  assign cpu_sel_wr = cpu_strobe & ~cpu_rnw & ~cpu_rs;
  assign busy_int   = (state == SEL) || (state == DAT) || (state == RESTORE);

  // cpu_fwd marks a CPU access that actually reaches the CRTC; only those stall the loader.
`ifdef CRTC_PRESET_LOCK_EN
  assign cpu_fwd = cpu_strobe & ~(busy_int & ~cpu_rnw);
`else
  assign cpu_fwd = cpu_strobe;
`endif

  function automatic logic [7:0] rom_value(input logic [1:0] p, input logic [3:0] r);
    logic [7:0] v;
    v = 8'd0;
    case (r)
      4'd0:  v = 8'd63;
      4'd1:  v = (p == 2'd2) ? 8'd48 : (p == 2'd3) ? 8'd32 : 8'd40;
      4'd2:  v = (p == 2'd2) ? 8'd50 : (p == 2'd3) ? 8'd42 : 8'd46;
      4'd3:  v = 8'h8E;
      4'd4:  v = (p == 2'd1) ? 8'd31 : 8'd38;
      4'd6:  v = (p == 2'd2) ? 8'd35 : (p == 2'd3) ? 8'd32 : 8'd25;
      4'd7:  begin
        case (p)
          2'd0:    v = 8'd30;
          2'd1:    v = 8'd28;
          2'd2:    v = 8'd35;
          default: v = 8'd34;
        endcase
      end
      4'd9:  v = 8'd7;
      4'd12: v = (p == 2'd2) ? 8'h0C : 8'h30;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      state <= IDLE;
      idx   <= 4'd0;
      psel  <= 2'd0;
      sh    <= 5'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      psel  <= psel_nxt;
      if (cpu_sel_wr)
        sh <= cpu_di[4:0];
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    psel_nxt  = psel;
    ld_drive  = 1'b0;
    ld_rs     = 1'b0;
    ld_di     = 8'd0;
    done_int  = 1'b0;
    unique case (state)
      IDLE: begin
        if (preset_req) begin
          psel_nxt  = preset_sel;
          idx_nxt   = 4'd0;
          state_nxt = SEL;
        end
      end
      SEL: begin
        if (!cpu_fwd) begin
          ld_drive  = 1'b1;
          ld_di     = {4'b0000, idx};
          state_nxt = DAT;
        end
      end
      DAT: begin
        if (!cpu_fwd) begin
          ld_drive = 1'b1;
          ld_rs    = 1'b1;
          ld_di    = rom_value(psel, idx);
          if (idx == 4'd15) begin
            state_nxt = RESTORE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = SEL;
          end
        end else if (cpu_sel_wr) begin
          // The CPU moved the CRTC index under us; reselect before writing data.
          state_nxt = SEL;
        end
      end
      RESTORE: begin
        if (!cpu_fwd) begin
          ld_drive  = 1'b1;
          ld_di     = {3'b000, sh};
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_int  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign preset_busy = busy_int & nRESET;
  assign preset_done = done_int & nRESET;

  // Reset blanks the loader drive immediately so an aborted load issues nothing further.
  always_comb begin
    crtc_enable = 1'b0;
    crtc_ncs    = 1'b1;
    crtc_rnw    = 1'b1;
    crtc_rs     = 1'b0;
    crtc_di     = 8'd0;
    if (cpu_fwd) begin
      crtc_enable = cpu_en;
      crtc_ncs    = cpu_ncs;
      crtc_rnw    = cpu_rnw;
      crtc_rs     = cpu_rs;
      crtc_di     = cpu_di;
    end else if (ld_drive && nRESET) begin
      crtc_enable = 1'b1;
      crtc_ncs    = 1'b0;
      crtc_rnw    = 1'b0;
      crtc_rs     = ld_rs;
      crtc_di     = ld_di;
    end
  end

  assign cpu_do = crtc_do;

endmodule

// File: tb/tb_crtc_preset_loader.sv
// Directed and randomized bench for crtc_preset_loader with a small UM6845R register model.
module tb_crtc_preset_loader;

  logic       CLOCK = 1'b0;
  logic       nRESET;
  logic       preset_req;
  logic [1:0] preset_sel;
  logic       preset_busy;
  logic       preset_done;
  logic       cpu_en, cpu_ncs, cpu_rnw, cpu_rs;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       crtc_enable, crtc_ncs, crtc_rnw, crtc_rs;
  logic [7:0] crtc_di;
  logic [7:0] crtc_do;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] crtcRegs [0:31];
  logic [4:0] crtcIdx = 5'd0;
  int         writeCount = 0;
  logic       clearRegs = 1'b0;

  always #5 CLOCK = ~CLOCK;

  crtc_preset_loader dut (
    .CLOCK(CLOCK), .nRESET(nRESET),
    .preset_req(preset_req), .preset_sel(preset_sel),
    .preset_busy(preset_busy), .preset_done(preset_done),
    .cpu_en(cpu_en), .cpu_ncs(cpu_ncs), .cpu_rnw(cpu_rnw), .cpu_rs(cpu_rs),
    .cpu_di(cpu_di), .cpu_do(cpu_do),
    .crtc_enable(crtc_enable), .crtc_ncs(crtc_ncs), .crtc_rnw(crtc_rnw), .crtc_rs(crtc_rs),
    .crtc_di(crtc_di), .crtc_do(crtc_do)
  );

  // CRTC host port: index latch plus register file, written on any enabled write cycle.
  always @(posedge CLOCK) begin
    if (clearRegs) begin
      for (int k = 0; k < 32; k++) crtcRegs[k] <= 8'hEE;
    end else if (crtc_enable && !crtc_ncs && !crtc_rnw) begin
      writeCount <= writeCount + 1;
      if (!crtc_rs) crtcIdx <= crtc_di[4:0];
      else          crtcRegs[crtcIdx] <= crtc_di;
    end
  end

  assign crtc_do = crtcRegs[crtcIdx];

  function automatic logic [7:0] expReg(input int p, input int r);
    logic [7:0] v [16];
    for (int k = 0; k < 16; k++) v[k] = 8'd0;
    v[0] = 8'd63; v[3] = 8'h8E; v[9] = 8'd7;
    v[1] = 8'd40; v[2] = 8'd46; v[4] = 8'd38; v[6] = 8'd25; v[7] = 8'd30; v[12] = 8'h30;
    if (p == 1) begin v[4] = 8'd31; v[7] = 8'd28; end
    if (p == 2) begin v[1] = 8'd48; v[2] = 8'd50; v[6] = 8'd35; v[7] = 8'd35; v[12] = 8'h0C; end
    if (p == 3) begin v[1] = 8'd32; v[2] = 8'd42; v[6] = 8'd32; v[7] = 8'd34; end
    return v[r];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idleCpu();
    cpu_en = 1'b0; cpu_ncs = 1'b1; cpu_rnw = 1'b1; cpu_rs = 1'b0; cpu_di = 8'd0;
  endtask

  task automatic applyStimulus(input logic rnw, input logic rs, input logic [7:0] di);
    cpu_en = 1'b1; cpu_ncs = 1'b0; cpu_rnw = rnw; cpu_rs = rs; cpu_di = di;
  endtask

  task automatic cpuWrite(input logic rs, input logic [7:0] di);
    applyStimulus(1'b0, rs, di);
    tick();
    idleCpu();
  endtask

  task automatic cpuRead(input logic [4:0] r, output logic [7:0] d);
    cpuWrite(1'b0, {3'b000, r});
    applyStimulus(1'b1, 1'b1, 8'd0);
    @(negedge CLOCK);
    d = cpu_do;
    tick();
    idleCpu();
  endtask

  task automatic wipeRegs();
    clearRegs = 1'b1;
    tick();
    clearRegs = 1'b0;
  endtask

  task automatic checkRegs(input int p, input int ovrIdx, input logic [7:0] ovrVal);
    for (int r = 0; r < 16; r++)
      checkOutput($sformatf("p%0d_R%0d", p, r), crtcRegs[r],
                  (r == ovrIdx) ? ovrVal : expReg(p, r));
  endtask

  // Cycle 1 is the cycle after the edge that samples preset_req.
  task automatic runLoad(input logic [1:0] sel, input logic [63:0] stallMask,
                         input int clobCycle, input logic [4:0] clobVal,
                         input int dataWrCycle, output int doneCycle, output int busyCount);
    preset_sel = sel;
    preset_req = 1'b1;
    tick();
    preset_req = 1'b0;
    preset_sel = 2'($urandom);
    doneCycle = -1;
    busyCount = 0;
    for (int c = 1; c < 200 && doneCycle < 0; c++) begin
      idleCpu();
      if (c < 64 && stallMask[c]) applyStimulus(1'b1, 1'($urandom), 8'($urandom));
      if (c == clobCycle)   applyStimulus(1'b0, 1'b0, {3'b000, clobVal});
      if (c == dataWrCycle) applyStimulus(1'b0, 1'b1, 8'hAA);
      @(negedge CLOCK);
      if (preset_done) doneCycle = c;
      if (preset_busy) busyCount++;
      tick();
    end
    idleCpu();
    @(negedge CLOCK);
    checkOutput("done_one_cycle", {31'd0, preset_done}, 32'd0);
    tick();
  endtask

  initial begin
    int         dc, bc, wc0, expDone;
    logic [7:0] rd;
    logic [4:0] v;
    logic [1:0] s;
    logic [63:0] mask;

    idleCpu();
    preset_req = 1'b0;
    preset_sel = 2'd0;
    nRESET = 1'b0;
    tick(); tick();
    wipeRegs();
    @(negedge CLOCK);
    checkOutput("rst_busy", {31'd0, preset_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, preset_done}, 32'd0);
    checkOutput("rst_crtc_idle",
                {19'd0, crtc_enable, crtc_ncs, crtc_rnw, crtc_rs, crtc_di}, {19'd0, 4'b0110, 8'd0});
    tick();
    nRESET = 1'b1;
    tick();

    $display("[TB] preset 0, quiet bus");
    runLoad(2'd0, 64'd0, 0, 5'd0, 0, dc, bc);
    checkOutput("p0_done_cycle", dc, 34);
    checkOutput("p0_busy_cycles", bc, 33);
    checkOutput("p0_restore_idx", {27'd0, crtcIdx}, 32'd0);
    checkRegs(0, -1, 8'd0);
    cpuRead(5'd0, rd);  checkOutput("p0_read_R0", rd, 63);
    cpuRead(5'd4, rd);  checkOutput("p0_read_R4", rd, 38);
    cpuRead(5'd7, rd);  checkOutput("p0_read_R7", rd, 30);
    cpuRead(5'd12, rd); checkOutput("p0_read_R12", rd, 32'h30);

    $display("[TB] preset 1 with CPU index 0Eh");
    wipeRegs();
    cpuWrite(1'b0, 8'h0E);
    runLoad(2'd1, 64'd0, 0, 5'd0, 0, dc, bc);
    checkOutput("p1_done_cycle", dc, 34);
    checkOutput("p1_restore_idx", {27'd0, crtcIdx}, 32'h0E);
    checkRegs(1, -1, 8'd0);
    cpuWrite(1'b1, 8'h55);
    checkOutput("p1_cpu_R14", crtcRegs[14], 32'h55);

    $display("[TB] preset 2, CPU select 03h during DAT of R5");
    wipeRegs();
    wc0 = writeCount;
    runLoad(2'd2, 64'd0, 12, 5'd3, 0, dc, bc);
`ifdef CRTC_PRESET_LOCK_EN
    checkOutput("p2_done_cycle", dc, 34);
    checkOutput("p2_write_count", writeCount - wc0, 33);
`else
    checkOutput("p2_done_cycle", dc, 36);
    checkOutput("p2_write_count", writeCount - wc0, 35);
`endif
    checkOutput("p2_restore_idx", {27'd0, crtcIdx}, 32'h03);
    checkRegs(2, -1, 8'd0);

    $display("[TB] ten-cycle CPU read stall");
    wipeRegs();
    s = 2'($urandom);
    mask = 64'd0;
    for (int c = 10; c < 20; c++) mask[c] = 1'b1;
    runLoad(s, mask, 0, 5'd0, 0, dc, bc);
    checkOutput("stall_done_cycle", dc, 44);
    checkRegs(int'(s), -1, 8'd0);

    $display("[TB] CPU data write at cycle 5 of a load");
    wipeRegs();
    cpuWrite(1'b0, 8'h09);
    runLoad(2'd0, 64'd0, 0, 5'd0, 5, dc, bc);
`ifdef CRTC_PRESET_LOCK_EN
    checkOutput("lock_done_cycle", dc, 34);
    checkRegs(0, -1, 8'd0);
`else
    checkOutput("wr_done_cycle", dc, 35);
    checkRegs(0, 1, 8'hAA);
`endif

    $display("[TB] reset in the middle of a load");
    wipeRegs();
    cpuWrite(1'b0, 8'h11);
    preset_sel = 2'd2;
    preset_req = 1'b1;
    tick();
    preset_req = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    nRESET = 1'b0;
    tick();
    @(negedge CLOCK);
    checkOutput("midrst_busy", {31'd0, preset_busy}, 32'd0);
    wc0 = writeCount;
    tick();
    nRESET = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    checkOutput("midrst_no_writes", writeCount - wc0, 0);
    checkOutput("midrst_no_restore", {27'd0, crtcIdx}, 32'd5);
    wipeRegs();
    runLoad(2'd3, 64'd0, 0, 5'd0, 0, dc, bc);
    checkOutput("p3_done_cycle", dc, 34);
    checkOutput("p3_restore_idx", {27'd0, crtcIdx}, 32'd0);
    checkOutput("p3_R1", crtcRegs[1], 32);
    checkRegs(3, -1, 8'd0);

    $display("[TB] randomized loads with read contention");
    for (int n = 0; n < 6; n++) begin
      wipeRegs();
      v = 5'($urandom_range(0, 31));
      s = 2'($urandom_range(0, 3));
      cpuWrite(1'b0, {3'b000, v});
      mask = 64'd0;
      for (int c = 1; c <= 30; c++) mask[c] = ($urandom_range(0, 3) == 0);
      expDone = 34 + $countones(mask);
      wc0 = writeCount;
      runLoad(s, mask, 0, 5'd0, 0, dc, bc);
      checkOutput($sformatf("rnd%0d_done_cycle", n), dc, expDone);
      checkOutput($sformatf("rnd%0d_busy_cycles", n), bc, expDone - 1);
      checkOutput($sformatf("rnd%0d_writes", n), writeCount - wc0, 33);
      checkOutput($sformatf("rnd%0d_restore_idx", n), {27'd0, crtcIdx}, {27'd0, v});
      checkRegs(int'(s), -1, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crtc_preset_loader.md
# crtc_preset_loader

Programs one of four built-in CRTC register sets (R0–R15) into the UM6845R through its host register port, sharing that port with the Z80 I/O path. Sits between the CPU I/O decode and the CRTC's ENABLE/nCS/R_nW/RS/DI/DO pins. Used for video-mode presets from the OSD and for boot-time initialisation. Preserves the CPU's selected register index across a load, so interrupted CPU select/data pairs stay coherent.

## Interface
Parameters:
- none.

Ports:
- CLOCK  in  1  system clock.
- nRESET  in  1  reset, synchronous, active-low.
- preset_req  in  1  start a load; sampled only in IDLE.
- preset_sel  in  2  preset index, latched with preset_req.
- preset_busy  out  1  high while a load is in progress.
- preset_done  out  1  one-cycle pulse when a load completes.
- cpu_en, cpu_ncs, cpu_rnw, cpu_rs  in  1 each  CPU-side CRTC strobes, with the same meaning as the CRTC pins.
- cpu_di  in  8  CPU write data.
- cpu_do  out  8  CPU read data; equal to crtc_do, combinational.
- crtc_enable, crtc_ncs, crtc_rnw, crtc_rs  out  1 each  to the CRTC.
- crtc_di  out  8  to the CRTC.
- crtc_do  in  8  from the CRTC.

## Operation
- A CPU strobe is `cpu_en & ~cpu_ncs`. A CPU select write is a strobe with `~cpu_rnw & ~cpu_rs`.
- Shadow index `sh[4:0]`:
  - Reset value 0.
  - Loads `cpu_di[4:0]` on every CPU select write, in any state, whether or not the write reaches the CRTC.
- Output mux (combinational):
  - A CPU strobe forwards the cpu_* signals to crtc_*.
  - Otherwise the loader drives crtc_* in states SEL, DAT and RESTORE.
  - Otherwise the idle value: enable=0, ncs=1, rnw=1, rs=0, di=0.
- Loader write cycle: enable=1, ncs=0, rnw=0. SEL/RESTORE drive rs=0; DAT drives rs=1.
- State machine:
  - IDLE: on preset_req, latch preset_sel, set i=0, go to SEL.
  - SEL: if no CPU strobe, drive di={3'b0,i} and go to DAT. Otherwise stay in SEL.
  - DAT, no CPU strobe: drive di=ROM[p][i]. If i=15 go to RESTORE; else i++ and go to SEL.
  - DAT, CPU select write: go back to SEL, because the CRTC index was clobbered.
  - DAT, any other CPU strobe: stay in DAT.
  - RESTORE: if no CPU strobe, drive di={3'b0,sh} and go to DONE. Otherwise stay in RESTORE.
  - DONE: preset_done=1, then go to IDLE.
- preset_busy=1 in SEL, DAT and RESTORE. preset_req is ignored in every state except IDLE.
- Preset ROM values (decimal; hex where marked). R5, R8, R10, R11, R13, R14 and R15 are 0 in every preset.
  - p0, 50 Hz: R0=63 R1=40 R2=46 R3=8Eh R4=38 R6=25 R7=30 R9=7 R12=30h.
  - p1, 60 Hz: as p0, except R4=31 R7=28.
  - p2, overscan: R0=63 R1=48 R2=50 R3=8Eh R4=38 R6=35 R7=35 R9=7 R12=0Ch.
  - p3, 32-column: R0=63 R1=32 R2=42 R3=8Eh R4=38 R6=32 R7=34 R9=7 R12=30h.
- Reset (synchronous) forces the following, regardless of state (mid-load included):
  - state=IDLE, i=0, sh=0.
  - preset_busy=0, preset_done=0.
  - crtc_* at the idle value unless a CPU strobe is present.
  - A partially written preset is left as-is; no restore write is issued.

## Timing
- preset_req is sampled at edge 0. With no contention:
  - SEL/DAT writes occupy cycles 1–32.
  - RESTORE occupies cycle 33.
  - preset_done is high in cycle 34; preset_busy falls at the start of cycle 34.
- Each cycle with a CPU strobe delays the loader by one cycle. Each CPU select write that lands in DAT costs one extra SEL cycle.
- Loader writes are issued every CLOCK and are independent of CLKEN, because the CRTC latches register writes on any CLOCK edge.
- cpu_do has zero latency (passthrough). The CPU never sees wait states.

## Configuration
- `CRTC_PRESET_LOCK_EN` defined:
  - While preset_busy=1, CPU writes are not forwarded; crtc_* keep the loader or idle drive. The shadow still updates.
  - CPU reads are forwarded as normal.
  - A load with no CPU reads always takes exactly 34 cycles.
- `CRTC_PRESET_LOCK_EN` undefined: the CPU-priority arbitration described above applies.

## Test plan
- Reset, then preset_req with sel=0 and no CPU traffic:
  - CRTC registers read R0=63, R4=38, R7=30, R12=30h.
  - preset_done pulses in cycle 34.
  - The final select write carries 0.
- CPU select write 0Eh, then preset_req with sel=1 -> R4=31, R7=28; the RESTORE write drives index 0Eh; a following CPU data write 55h lands in R14.
- sel=2, with a CPU select write 03h during the DAT phase for i=5 -> the loader re-issues select 5, then data 0; at the end R3=8Eh, R5=0, and the restore index is 03h.
- CPU strobe held for 10 cycles mid-load (lock undefined) -> the loader stalls 10 cycles, preset_done comes 10 cycles later, and the register contents are correct.
- nRESET asserted at cycle 12 of a load -> next cycle preset_busy=0, no further loader writes occur, and a new preset_req with sel=3 completes with R1=32.
- `CRTC_PRESET_LOCK_EN` defined, CPU data write during busy -> the write is not forwarded, preset_done comes at cycle 34, and the preset values are intact.
